llc_update_pkt_tx: RTL and testbench

Transmit side of the process-to-update packet channel in the LLC pipeline. Accepts completion events from the process stage, encodes them into `fifo_proc_update_packet`, and buffers them in an internal FIFO. The FIFO is drained by the update stage through `fifo_update_out` / `fifo_empty_update` / `fifo_pop_update`. The block also tracks reset and flush resumes that are in flight between the two stages.

---
 rtl/llc_update_pkt_tx_pkg.sv | 39 +++
 rtl/llc_update_pkt_tx_if.sv | 53 +++++
 rtl/llc_pkt_fifo.sv | 61 ++++++
 rtl/llc_update_pkt_tx.sv | 89 ++++++++
 tb/tb_llc_update_pkt_tx.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/llc_update_pkt_tx_pkg.sv
// Shared types and constants for the process-to-update packet channel.
// - LLC_UPDATE_FIFO_DEPTH: default depth of the update FIFO.
// - fifo_proc_update_packet: entry passed from the process stage to the update stage.
// - encode_pkt(): applies the resume-flag priority rules to a raw event.
package llc_update_pkt_tx_pkg;

  localparam int unsigned LLC_UPDATE_FIFO_DEPTH = 4;
  localparam int unsigned TablePtrW = 3;

  typedef struct packed {
    logic                 is_rst_to_resume;
    logic                 is_flush_to_resume;
    logic                 is_req_to_resume;
    logic                 is_rst_to_get;
    logic                 is_req_to_get;
    logic                 is_rsp_to_get;
    logic                 is_dma_req_to_get;
    logic                 is_dma_read_to_resume;
    logic                 is_dma_write_to_resume;
    logic [TablePtrW-1:0] table_pointer_to_remove;
  } fifo_proc_update_packet;

  // A reset resume masks every other flag; a flush resume masks everything but reset.
  function automatic fifo_proc_update_packet encode_pkt(input fifo_proc_update_packet raw);
    fifo_proc_update_packet pkt;
    pkt = raw;
    if (raw.is_rst_to_resume) begin
      pkt                         = '0;
      pkt.is_rst_to_resume        = 1'b1;
      pkt.table_pointer_to_remove = raw.table_pointer_to_remove;
    end else if (raw.is_flush_to_resume) begin
      pkt                         = '0;
      pkt.is_flush_to_resume      = 1'b1;
      pkt.table_pointer_to_remove = raw.table_pointer_to_remove;
    end
    return pkt;
  endfunction

endpackage

// File: rtl/llc_update_pkt_tx_if.sv
// Handshake/bus bundle between the process stage, llc_update_pkt_tx and the update stage.
// slave : view of llc_update_pkt_tx (receives events and pops, drives FIFO status).
// master: view of the surrounding stages (drive events, pops and clears).
interface llc_update_pkt_tx_if #(
  parameter int unsigned Depth = 4
);
  import llc_update_pkt_tx_pkg::*;

  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic                   proc_done_valid;
  logic                   proc_done_ready;
  logic                   is_rst_to_resume;
  logic                   is_flush_to_resume;
  logic                   is_req_to_resume;
  logic                   is_rst_to_get;
  logic                   is_req_to_get;
  logic                   is_rsp_to_get;
  logic                   is_dma_req_to_get;
  logic                   is_dma_read_to_resume;
  logic                   is_dma_write_to_resume;
  logic [TablePtrW-1:0]   table_pointer_in;
  fifo_proc_update_packet fifo_update_out;
  logic                   fifo_empty_update;
  logic                   fifo_pop_update;
  logic                   clr_rst_to_resume_in_pipeline_update;
  logic                   clr_flush_to_resume_in_pipeline_update;
  logic                   rst_to_resume_in_pipeline;
  logic                   flush_to_resume_in_pipeline;
  logic                   fifo_full_update;
  logic [CntW-1:0]        fifo_count;

  modport slave (
    input  proc_done_valid, is_rst_to_resume, is_flush_to_resume, is_req_to_resume,
           is_rst_to_get, is_req_to_get, is_rsp_to_get, is_dma_req_to_get,
           is_dma_read_to_resume, is_dma_write_to_resume, table_pointer_in,
           fifo_pop_update, clr_rst_to_resume_in_pipeline_update,
           clr_flush_to_resume_in_pipeline_update,
    output proc_done_ready, fifo_update_out, fifo_empty_update, rst_to_resume_in_pipeline,
           flush_to_resume_in_pipeline, fifo_full_update, fifo_count
  );

  modport master (
    output proc_done_valid, is_rst_to_resume, is_flush_to_resume, is_req_to_resume,
           is_rst_to_get, is_req_to_get, is_rsp_to_get, is_dma_req_to_get,
           is_dma_read_to_resume, is_dma_write_to_resume, table_pointer_in,
           fifo_pop_update, clr_rst_to_resume_in_pipeline_update,
           clr_flush_to_resume_in_pipeline_update,
    input  proc_done_ready, fifo_update_out, fifo_empty_update, rst_to_resume_in_pipeline,
           flush_to_resume_in_pipeline, fifo_full_update, fifo_count
  );

endinterface

// File: rtl/llc_pkt_fifo.sv
// Generic typed circular FIFO for the LLC pipeline.
// clk/rst (sync, active-low); push_i/data_i write; pop_i consumes head data_o (combinational
// read, don't-care when empty); full_o, empty_o, count_o report occupancy.
// Push when full and pop when empty are ignored; a pop never frees space for a same-cycle push.
module llc_pkt_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         pkt_t = logic
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  pkt_t                     data_i,
  input  logic                     pop_i,
  output pkt_t                     data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  pkt_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push_en, pop_en;

  always_comb begin
    full_o   = (count_q == (PtrW + 1)'(Depth));
    empty_o  = (count_q == '0);
    push_en  = push_i && !full_o;
    pop_en   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_en && !pop_en)      count_d = count_q + (PtrW + 1)'(1);
    else if (pop_en && !push_en) count_d = count_q - (PtrW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; writes are still blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && push_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/llc_update_pkt_tx.sv
// Transmit side of the process-to-update packet channel.
// clk/rst (sync, active-low) plus bus (llc_update_pkt_tx_if.slave): completion events are
// encoded and buffered in llc_pkt_fifo, drained by the update stage, and reset/flush resumes
// still in flight are tracked by two saturating counters.
module llc_update_pkt_tx
  import llc_update_pkt_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = LLC_UPDATE_FIFO_DEPTH
) (
  input logic                clk,
  input logic                rst,
  llc_update_pkt_tx_if.slave bus
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fifo_proc_update_packet raw_pkt, enc_pkt;
  logic                   full, empty, push;
  logic [CntW-1:0]        count;
  logic [CntW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CntW-1:0]        flush_cnt_q, flush_cnt_d;

  always_comb begin
    raw_pkt = '{
      is_rst_to_resume:        bus.is_rst_to_resume,
      is_flush_to_resume:      bus.is_flush_to_resume,
      is_req_to_resume:        bus.is_req_to_resume,
      is_rst_to_get:           bus.is_rst_to_get,
      is_req_to_get:           bus.is_req_to_get,
      is_rsp_to_get:           bus.is_rsp_to_get,
      is_dma_req_to_get:       bus.is_dma_req_to_get,
      is_dma_read_to_resume:   bus.is_dma_read_to_resume,
      is_dma_write_to_resume:  bus.is_dma_write_to_resume,
      table_pointer_to_remove: bus.table_pointer_in
    };
    enc_pkt = encode_pkt(raw_pkt);
  end

  // Ready comes from registered occupancy only, so there is no valid-to-ready path.
  assign push = bus.proc_done_valid && !full;

  llc_pkt_fifo #(
    .Depth (FIFO_DEPTH),
    .pkt_t (fifo_proc_update_packet)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (enc_pkt),
    .pop_i   (bus.fifo_pop_update),
    .data_o  (bus.fifo_update_out),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Simultaneous increment and clear cancel; a clear at zero saturates.
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (push && enc_pkt.is_rst_to_resume) begin
      if (!bus.clr_rst_to_resume_in_pipeline_update) rst_cnt_d = rst_cnt_q + CntW'(1);
    end else if (bus.clr_rst_to_resume_in_pipeline_update && rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - CntW'(1);
    end
    if (push && enc_pkt.is_flush_to_resume) begin
      if (!bus.clr_flush_to_resume_in_pipeline_update) flush_cnt_d = flush_cnt_q + CntW'(1);
    end else if (bus.clr_flush_to_resume_in_pipeline_update && flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rst_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.proc_done_ready             = !full;
  assign bus.fifo_full_update            = full;
  assign bus.fifo_empty_update           = empty;
  assign bus.fifo_count                  = count;
  assign bus.rst_to_resume_in_pipeline   = (rst_cnt_q != '0);
  assign bus.flush_to_resume_in_pipeline = (flush_cnt_q != '0);

endmodule

// File: tb/tb_llc_update_pkt_tx.sv
// Scoreboard bench for llc_update_pkt_tx: the stimulus process drives events one cycle at a
// time; the monitor at each falling edge checks status against a queue-based model, compares
// popped heads with the queue front, and then advances the model for the coming edge.
module tb_llc_update_pkt_tx;
  import llc_update_pkt_tx_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  llc_update_pkt_tx_if #(.Depth(DEPTH)) bus ();

  llc_update_pkt_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  fifo_proc_update_packet exp_q[$];
  int rst_m   = 0;
  int flush_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder; flags order: rst,flush,req_res,rst_get,req_get,rsp_get,dma_req,dma_rd,dma_wr
  function automatic fifo_proc_update_packet model_enc(input logic [8:0] f, input logic [2:0] p);
    fifo_proc_update_packet e;
    e = '0;
    e.table_pointer_to_remove = p;
    if (f[8])      e.is_rst_to_resume = 1'b1;
    else if (f[7]) e.is_flush_to_resume = 1'b1;
    else begin
      e.is_req_to_resume       = f[6];
      e.is_rst_to_get          = f[5];
      e.is_req_to_get          = f[4];
      e.is_rsp_to_get          = f[3];
      e.is_dma_req_to_get      = f[2];
      e.is_dma_read_to_resume  = f[1];
      e.is_dma_write_to_resume = f[0];
    end
    return e;
  endfunction

  function automatic logic [8:0] cur_flags();
    return {bus.is_rst_to_resume, bus.is_flush_to_resume, bus.is_req_to_resume,
            bus.is_rst_to_get, bus.is_req_to_get, bus.is_rsp_to_get, bus.is_dma_req_to_get,
            bus.is_dma_read_to_resume, bus.is_dma_write_to_resume};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      int sz;
      bit pushing;
      fifo_proc_update_packet e;
      sz = exp_q.size();
      chk("empty", 32'(bus.fifo_empty_update), 32'(sz == 0));
      chk("full", 32'(bus.fifo_full_update), 32'(sz == DEPTH));
      chk("ready", 32'(bus.proc_done_ready), 32'(sz != DEPTH));
      chk("count", 32'(bus.fifo_count), 32'(sz));
      chk("rst_in_pipe", 32'(bus.rst_to_resume_in_pipeline), 32'(rst_m != 0));
      chk("flush_in_pipe", 32'(bus.flush_to_resume_in_pipeline), 32'(flush_m != 0));
      if (!rst) begin
        exp_q.delete();
        rst_m   = 0;
        flush_m = 0;
      end else begin
        pushing = bus.proc_done_valid && (sz < DEPTH);
        e = model_enc(cur_flags(), bus.table_pointer_in);
        if (bus.fifo_pop_update && sz > 0) begin
          chk("head", 32'(bus.fifo_update_out), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        if (pushing) exp_q.push_back(e);
        rst_m   += int'(pushing && e.is_rst_to_resume)
                 - int'(bus.clr_rst_to_resume_in_pipeline_update);
        flush_m += int'(pushing && e.is_flush_to_resume)
                 - int'(bus.clr_flush_to_resume_in_pipeline_update);
        if (rst_m < 0)   rst_m = 0;
        if (flush_m < 0) flush_m = 0;
      end
    end
  end

  task automatic drive(input logic v, input logic [8:0] f, input logic [2:0] p, input logic pop,
                       input logic clr_r, input logic clr_f);
    bus.proc_done_valid        = v;
    {bus.is_rst_to_resume, bus.is_flush_to_resume, bus.is_req_to_resume,
     bus.is_rst_to_get, bus.is_req_to_get, bus.is_rsp_to_get, bus.is_dma_req_to_get,
     bus.is_dma_read_to_resume, bus.is_dma_write_to_resume} = f;
    bus.table_pointer_in       = p;
    bus.fifo_pop_update        = pop;
    bus.clr_rst_to_resume_in_pipeline_update   = clr_r;
    bus.clr_flush_to_resume_in_pipeline_update = clr_f;
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] FRst   = 9'b1_0000_0000;
  localparam logic [8:0] FFlush = 9'b0_1000_0000;
  localparam logic [8:0] FReqG  = 9'b0_0001_0000;
  localparam logic [8:0] FRspG  = 9'b0_0000_1000;

  initial begin
    logic [8:0] f;
    // Reset held for two cycles with valid asserted; nothing may be written.
    rst = 1'b0;
    bus.proc_done_valid = 1'b1;
    drive(1'b1, 9'h1ff, 3'd2, 1'b1, 1'b1, 1'b1);
    mon_en = 1'b1;
    drive(1'b1, 9'h0a5, 3'd6, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Single push, then pop.
    drive(1'b1, FReqG, 3'd5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Priority: rst wins over flush and rsp; in-pipeline held until cleared.
    drive(1'b1, FRst | FFlush | FRspG, 3'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Fill, rejected push with pop at full, then accepted push.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, FReqG, 3'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, FRspG, 3'd7, 1'b1, 1'b0, 1'b0);
    drive(1'b1, FRspG, 3'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Wrap-around with a pop every cycle after the first push.
    for (int i = 0; i < 8; i++) drive(1'b1, FReqG, 3'(i), i != 0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Counter corners.
    drive(1'b1, FFlush, 3'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, FFlush, 3'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, FFlush, 3'd4, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);

    // Randomized traffic; resume flags throttled so the in-flight counters stay in range.
    for (int i = 0; i < 400; i++) begin
      f = 9'($urandom_range(0, 511));
      if (rst_m >= 4)   f[8] = 1'b0;
      if (flush_m >= 4) f[7] = 1'b0;
      drive($urandom_range(0, 3) != 0, f, 3'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Mid-traffic reset with everything active, then drain.
    rst = 1'b0;
    drive(1'b1, 9'h1ff, 3'd7, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    drive(1'b1, FReqG, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
